seg7_scan_driver: RTL and testbench

//  Time-multiplexed driver for the Nexys 8-digit common-anode 7-segment display.

---
 rtl/seg7_scan_driver_pkg.sv | 29 ++
 rtl/seg7_scan_driver_if.sv | 25 ++
 rtl/seg7_scan_driver_hex_decode.sv | 32 +++
 rtl/seg7_scan_driver.sv | 110 +++++++++++
 tb/tb_seg7_scan_driver.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/seg7_scan_driver_pkg.sv
// Shared constants for the 7-segment scan driver: digit count, hex glyphs
// (active-high, bit0 = CA .. bit6 = CG) and the slot phase type.
package seg7_scan_driver_pkg;

   localparam int NUM_DIGITS = 8;

   localparam logic [6:0] SEG_0 = 7'h3F;
   localparam logic [6:0] SEG_1 = 7'h06;
   localparam logic [6:0] SEG_2 = 7'h5B;
   localparam logic [6:0] SEG_3 = 7'h4F;
   localparam logic [6:0] SEG_4 = 7'h66;
   localparam logic [6:0] SEG_5 = 7'h6D;
   localparam logic [6:0] SEG_6 = 7'h7D;
   localparam logic [6:0] SEG_7 = 7'h07;
   localparam logic [6:0] SEG_8 = 7'h7F;
   localparam logic [6:0] SEG_9 = 7'h6F;
   localparam logic [6:0] SEG_A = 7'h77;
   localparam logic [6:0] SEG_B = 7'h7C;
   localparam logic [6:0] SEG_C = 7'h39;
   localparam logic [6:0] SEG_D = 7'h5E;
   localparam logic [6:0] SEG_E = 7'h79;
   localparam logic [6:0] SEG_F = 7'h71;

   typedef enum logic {
      PHASE_BLANK = 1'b0,
      PHASE_ON    = 1'b1
   } phase_e;

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Bundle between the 7-seg register block (master) and the scan driver (slave):
// nibble/enable/dp inputs one way, board pins and frame_start the other.
interface seg7_scan_driver_if
   import seg7_scan_driver_pkg::*;
();

   logic [4*NUM_DIGITS-1:0] display;
   logic [NUM_DIGITS-1:0]   digit_enable;
   logic [NUM_DIGITS-1:0]   dp;
   logic [NUM_DIGITS-1:0]   anode;
   logic [6:0]              cathode;
   logic                    dp_pin;
   logic                    frame_start;

   modport master (
      output display, digit_enable, dp,
      input  anode, cathode, dp_pin, frame_start
   );

   modport slave (
      input  display, digit_enable, dp,
      output anode, cathode, dp_pin, frame_start
   );

endinterface

// File: rtl/seg7_scan_driver_hex_decode.sv
// Combinational hex nibble to active-high 7-segment glyph; shared with other
// display blocks.
module seg7_scan_driver_hex_decode
   import seg7_scan_driver_pkg::*;
(
   input  logic [3:0] nibble_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = SEG_0;
      case (nibble_i)
         4'h0:    seg_o = SEG_0;
         4'h1:    seg_o = SEG_1;
         4'h2:    seg_o = SEG_2;
         4'h3:    seg_o = SEG_3;
         4'h4:    seg_o = SEG_4;
         4'h5:    seg_o = SEG_5;
         4'h6:    seg_o = SEG_6;
         4'h7:    seg_o = SEG_7;
         4'h8:    seg_o = SEG_8;
         4'h9:    seg_o = SEG_9;
         4'hA:    seg_o = SEG_A;
         4'hB:    seg_o = SEG_B;
         4'hC:    seg_o = SEG_C;
         4'hD:    seg_o = SEG_D;
         4'hE:    seg_o = SEG_E;
         default: seg_o = SEG_F;
      endcase
   end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 8-digit 7-segment driver: scans one digit per slot, blanks
// the start of each slot against ghosting, and snapshots its inputs once per frame.
module seg7_scan_driver
   import seg7_scan_driver_pkg::*;
#(
   parameter int DIGIT_CYCLES = 100000,
   parameter int BLANK_CYCLES = 1000,
   parameter int ACTIVE_LOW   = 1
) (
   input  logic             clk,
   input  logic             reset,
   seg7_scan_driver_if.slave bus
);

   localparam int CW = $clog2(DIGIT_CYCLES);
   localparam int SW = $clog2(NUM_DIGITS);
   localparam logic [CW-1:0] CNT_LAST = CW'(DIGIT_CYCLES - 1);
   localparam logic          PIN_INV  = (ACTIVE_LOW != 0);

   if (DIGIT_CYCLES < 2) begin : g_bad_digit_cycles
      $error("seg7_scan_driver: DIGIT_CYCLES must be >= 2");
   end
   if (BLANK_CYCLES < 0 || BLANK_CYCLES >= DIGIT_CYCLES) begin : g_bad_blank_cycles
      $error("seg7_scan_driver: BLANK_CYCLES must be in 0..DIGIT_CYCLES-1");
   end
   if (ACTIVE_LOW != 0 && ACTIVE_LOW != 1) begin : g_bad_active_low
      $error("seg7_scan_driver: ACTIVE_LOW must be 0 or 1");
   end

   logic [CW-1:0]           cnt_q, cnt_d;
   logic [SW-1:0]           slot_q, slot_d;
   logic [4*NUM_DIGITS-1:0] disp_q;
   logic [NUM_DIGITS-1:0]   de_q, dp_q;
   logic [NUM_DIGITS-1:0]   anode_q, anode_d;
   logic [6:0]              cathode_q, cathode_d;
   logic                    dp_pin_q, dp_pin_d;
   logic                    frame_start_q;

   logic                    snap;
   logic                    cnt_wrap;
   logic [4*NUM_DIGITS-1:0] disp_eff;
   logic [NUM_DIGITS-1:0]   de_eff, dp_eff;
   logic [3:0]              nibble;
   logic [6:0]              seg;
   logic                    lit;
   phase_e                  phase;

   assign snap     = (slot_q == '0) && (cnt_q == '0);
   assign cnt_wrap = (cnt_q == CNT_LAST);
   assign cnt_d    = cnt_wrap ? '0 : cnt_q + 1'b1;
   assign slot_d   = cnt_wrap ? slot_q + 1'b1 : slot_q;

   // On the snapshot cycle the shadows are still stale, so look through to the inputs.
   assign disp_eff = snap ? bus.display      : disp_q;
   assign de_eff   = snap ? bus.digit_enable : de_q;
   assign dp_eff   = snap ? bus.dp           : dp_q;

   if (BLANK_CYCLES == 0) begin : g_no_blank
      assign phase = PHASE_ON;
   end else begin : g_blank
      localparam logic [CW-1:0] BLANK_LEN = CW'(BLANK_CYCLES);
      assign phase = (cnt_q < BLANK_LEN) ? PHASE_BLANK : PHASE_ON;
   end

   assign nibble = disp_eff[{slot_q, 2'b00} +: 4];

   seg7_scan_driver_hex_decode u_decode (
      .nibble_i (nibble),
      .seg_o    (seg)
   );

   // A disabled digit still owns its slot but keeps every pin inactive.
   assign lit       = (phase == PHASE_ON) && de_eff[slot_q];
   assign anode_d   = (lit ? ({{(NUM_DIGITS-1){1'b0}}, 1'b1} << slot_q) : '0)
                      ^ {NUM_DIGITS{PIN_INV}};
   assign cathode_d = (lit ? seg : 7'h00) ^ {7{PIN_INV}};
   assign dp_pin_d  = (lit && dp_eff[slot_q]) ^ PIN_INV;

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q         <= '0;
         slot_q        <= '0;
         disp_q        <= '0;
         de_q          <= '0;
         dp_q          <= '0;
         anode_q       <= {NUM_DIGITS{PIN_INV}};
         cathode_q     <= {7{PIN_INV}};
         dp_pin_q      <= PIN_INV;
         frame_start_q <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         slot_q        <= slot_d;
         if (snap) begin
            disp_q <= bus.display;
            de_q   <= bus.digit_enable;
            dp_q   <= bus.dp;
         end
         anode_q       <= anode_d;
         cathode_q     <= cathode_d;
         dp_pin_q      <= dp_pin_d;
         frame_start_q <= snap;
      end
   end

   assign bus.anode       = anode_q;
   assign bus.cathode     = cathode_q;
   assign bus.dp_pin      = dp_pin_q;
   assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver (DIGIT_CYCLES=8, BLANK_CYCLES=2, ACTIVE_LOW=1):
// stimulus queues hand-computed pin values per cycle, a negedge monitor pops and compares.
module tb_seg7_scan_driver;
   import seg7_scan_driver_pkg::*;

   // First snapshot edge: reset is held over edges 1..5 and released before edge 6.
   localparam int S = 6;

   typedef struct {
      int         cyc;
      string      name;
      logic [7:0] an;
      logic [6:0] ca;
      logic       dp;
      logic       fs;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   exp_t expQ[$];

   seg7_scan_driver_if bus ();

   seg7_scan_driver #(
      .DIGIT_CYCLES (8),
      .BLANK_CYCLES (2),
      .ACTIVE_LOW   (1)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic queueExpect(input int c, input string name, input logic [7:0] an,
                              input logic [6:0] ca, input logic dp, input logic fs);
      exp_t e;
      e.cyc = c; e.name = name; e.an = an; e.ca = ca; e.dp = dp; e.fs = fs;
      expQ.push_back(e);
   endtask

   task automatic applyStimulus(input logic [31:0] d, input logic [7:0] de, input logic [7:0] dpv);
      bus.display      = d;
      bus.digit_enable = de;
      bus.dp           = dpv;
   endtask

   task automatic waitCycle(input int target);
      while (cyc < target) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic checkOutput(input exp_t e);
      checks++;
      if (bus.anode !== e.an || bus.cathode !== e.ca || bus.dp_pin !== e.dp || bus.frame_start !== e.fs) begin
         failures++;
         $display("[TB] FAIL %s cyc=%0d got an=%h ca=%h dp=%b fs=%b required an=%h ca=%h dp=%b fs=%b",
                  e.name, cyc, bus.anode, bus.cathode, bus.dp_pin, bus.frame_start,
                  e.an, e.ca, e.dp, e.fs);
      end
   endtask

   // Monitor: every falling edge, retire all expectations due at this cycle.
   always @(negedge clk) begin : monitor
      exp_t e;
      while (expQ.size() > 0 && expQ[0].cyc <= cyc) begin
         e = expQ.pop_front();
         if (e.cyc < cyc) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s missed: due cyc=%0d now cyc=%0d", e.name, e.cyc, cyc);
         end else begin
            checkOutput(e);
         end
      end
   end

   initial begin
      reset = 1'b1;
      applyStimulus(32'h0, 8'h00, 8'h00);
      for (int i = 1; i <= 5; i++) queueExpect(i, "reset_hold", 8'hFF, 7'h7F, 1'b1, 1'b0);
      waitCycle(5);

      // Frame 0: 89ABCDEF, all digits on, no dp.
      queueExpect(S+0,  "snap_fs",     8'hFF, 7'h7F, 1'b1, 1'b1);
      queueExpect(S+1,  "slot0_blank", 8'hFF, 7'h7F, 1'b1, 1'b0);
      queueExpect(S+2,  "slot0_on_F",  8'hFE, 7'h0E, 1'b1, 1'b0);
      queueExpect(S+7,  "slot0_end_F", 8'hFE, 7'h0E, 1'b1, 1'b0);
      queueExpect(S+8,  "slot1_blank", 8'hFF, 7'h7F, 1'b1, 1'b0);
      queueExpect(S+10, "slot1_on_E",  8'hFD, 7'h06, 1'b1, 1'b0);
      queueExpect(S+58, "slot7_on_8",  8'h7F, 7'h00, 1'b1, 1'b0);
      queueExpect(S+63, "slot7_end_8", 8'h7F, 7'h00, 1'b1, 1'b0);
      queueExpect(S+64, "fs_period",   8'hFF, 7'h7F, 1'b1, 1'b1);
      queueExpect(S+65, "fs_one_cyc",  8'hFF, 7'h7F, 1'b1, 1'b0);
      reset = 1'b0;
      applyStimulus(32'h89AB_CDEF, 8'hFF, 8'h00);

      // Mid-frame change: must not appear until frame 1.
      waitCycle(S+10);
      queueExpect(S+66, "f1_slot0_0", 8'hFE, 7'h40, 1'b1, 1'b0);
      queueExpect(S+90, "f1_slot3_0", 8'hF7, 7'h40, 1'b1, 1'b0);
      applyStimulus(32'h0000_0000, 8'hFF, 8'h00);

      // Change during slot 3 of frame 1: keep showing "0" until frame 2.
      waitCycle(S+91);
      queueExpect(S+93,  "notear_slot3", 8'hF7, 7'h40, 1'b1, 1'b0);
      queueExpect(S+122, "notear_slot7", 8'h7F, 7'h40, 1'b1, 1'b0);
      queueExpect(S+127, "notear_end",   8'h7F, 7'h40, 1'b1, 1'b0);
      queueExpect(S+128, "f2_fs",        8'hFF, 7'h7F, 1'b1, 1'b1);
      queueExpect(S+130, "f2_slot0_1",   8'hFE, 7'h79, 1'b1, 1'b0);
      queueExpect(S+154, "f2_slot3_1",   8'hF7, 7'h79, 1'b1, 1'b0);
      applyStimulus(32'h1111_1111, 8'hFF, 8'h00);

      // Only digit 0 enabled, dp requested on disabled digit 1.
      waitCycle(S+140);
      queueExpect(S+192, "f3_fs",        8'hFF, 7'h7F, 1'b1, 1'b1);
      queueExpect(S+194, "de01_slot0",   8'hFE, 7'h40, 1'b1, 1'b0);
      queueExpect(S+200, "de01_s1_blnk", 8'hFF, 7'h7F, 1'b1, 1'b0);
      queueExpect(S+202, "de01_slot1",   8'hFF, 7'h7F, 1'b1, 1'b0);
      queueExpect(S+207, "de01_s1_end",  8'hFF, 7'h7F, 1'b1, 1'b0);
      queueExpect(S+226, "de01_slot4",   8'hFF, 7'h7F, 1'b1, 1'b0);
      queueExpect(S+250, "de01_slot7",   8'hFF, 7'h7F, 1'b1, 1'b0);
      applyStimulus(32'h0000_0000, 8'h01, 8'h02);

      // All digits on with dp on digit 1.
      waitCycle(S+200);
      queueExpect(S+256, "f4_fs",       8'hFF, 7'h7F, 1'b1, 1'b1);
      queueExpect(S+258, "dp_slot0",    8'hFE, 7'h40, 1'b1, 1'b0);
      queueExpect(S+266, "dp_slot1_on", 8'hFD, 7'h40, 1'b0, 1'b0);
      queueExpect(S+290, "dp_slot4",    8'hEF, 7'h40, 1'b1, 1'b0);
      queueExpect(S+298, "pre_reset_s5",8'hDF, 7'h40, 1'b1, 1'b0);
      applyStimulus(32'h0000_0000, 8'hFF, 8'h02);

      // One-cycle reset in slot 5, then a fresh snapshot and frame.
      waitCycle(S+298);
      queueExpect(S+299, "reset_pulse",  8'hFF, 7'h7F, 1'b1, 1'b0);
      queueExpect(S+300, "restart_fs",   8'hFF, 7'h7F, 1'b1, 1'b1);
      queueExpect(S+301, "restart_blnk", 8'hFF, 7'h7F, 1'b1, 1'b0);
      queueExpect(S+302, "restart_s0",   8'hFE, 7'h40, 1'b1, 1'b0);
      queueExpect(S+310, "restart_s1dp", 8'hFD, 7'h40, 1'b0, 1'b0);
      queueExpect(S+363, "restart_end",  8'h7F, 7'h40, 1'b1, 1'b0);
      queueExpect(S+364, "restart_fs2",  8'hFF, 7'h7F, 1'b1, 1'b1);
      reset = 1'b1;
      waitCycle(S+299);
      reset = 1'b0;

      waitCycle(S+366);
      checks++;
      if (expQ.size() != 0) begin
         failures++;
         $display("[TB] FAIL scoreboard_drain got %0d pending required 0", expQ.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
